taylor_core_sched: RTL and testbench
====================================

// Module: taylor_core_sched
// PURPOSE
//  Sequencer/arbiter for an array of N_CORES rede_taylor cores sharing one io_in stream.
//  - Releases per-core resets in a staggered sequence.
//  - Collects each core's result into a 1-deep slot.
//  - Drains slots round-robin onto one valid/ready result port.
//  - Replaces the priority-mux output selection.
// PARAMETERS
//  N_CORES  38  number of cores served
//  DW       28  core result width (signed)
//  STAGGER  9   cycles each core's reset-release slot lasts
//  IDX_W    $clog2(N_CORES)  localparam, core index width
// PORTS
//  clk         in   1           clock
//  rst_n       in   1           asynchronous reset, active-low
//  restart     in   1           sync pulse: re-reset all cores, rerun release sequence
//  core_rst    out  N_CORES     per-core reset, active-high (to rede_taylor rst)
//  core_valid  in   N_CORES     bit i = core i out_en==1 this cycle
//  core_data   in   N_CORES*DW  packed core results, core i at [i*DW +: DW]
//  out_valid   out  1           result available
//  out_ready   in   1           downstream accepts
//  out_data    out  DW          result value
//  out_idx     out  IDX_W       index of the producing core
//  all_up      out  1           every core released
//  ovf         out  1           sticky: a result was dropped
// BEHAVIOUR
//  Reset (rst_n=0): core_rst all 1; FSM=REL; idx=0; cnt=0; slots empty; rr_ptr=N_CORES-1.
//   Outputs reset: out_valid=0, out_data=0, out_idx=0, all_up=0, ovf=0.
//  FSM REL:
//   - core_rst[idx] goes 0 on the 1st cycle of slot idx; cnt counts 0..STAGGER-1.
//   - At cnt=STAGGER-1: cnt=0, idx++.
//   - After slot N_CORES-1: FSM=RUN, all_up=1.
//  FSM RUN: idle hold; no reset changes.
//  restart (either state), next edge:
//   - core_rst all 1; FSM=REL; idx=0; cnt=0; all_up=0; ovf=0.
//   - Slots and output register cleared; out_valid=0. Discarded data is not flagged.
//  Capture:
//   - core_valid[i]=1 with core_rst[i]=1: ignored.
//   - Otherwise slot i is written if empty or drained on the same edge (no overflow).
//   - If slot i is full and not drained, the new value is dropped and ovf is set.
//  Drain:
//   - When !out_valid || out_ready, grant the first full slot searching rr_ptr+1 upward, wrapping at N_CORES-1.
//   - Load out_data/out_idx, set out_valid, clear the slot, rr_ptr=grant.
//   - No full slot: out_valid falls after handshake.
//  Latency: core_valid at cycle t -> out_valid at t+2 when the port is free. Throughput 1 result/cycle.
//  out_valid && !out_ready: out_data/out_idx held stable.
//  Arithmetic: data passed unmodified, no sign/width change.
// CONFIGURATION
//  SCHED_OVF_CNT_EN defined:
//   - Adds port ovf_cnt out 16: saturating count of dropped results.
//   - Reset to 0 by rst_n and by restart; holds at 16'hFFFF.
//   - Multiple drops in one cycle add their count.
//  Undefined: port and counter absent; only sticky ovf.
// STRUCTURE
//  Package taylor_sched_pkg: DW, IDX_W, FSM enum {REL, RUN}.
//  Sub-module rr_arbiter (N-bit request, ptr -> one-hot grant + index), reusable elsewhere.
// TESTING
//  Release sequence (N=38, STAGGER=9): rst_n rises at cycle 0 ->
//   - core_rst[0]=0 at cycle 1; core_rst[k]=0 at cycle 1+9k.
//   - all_up=1 from cycle 343.
//  Single result: core 5 valid, data 28'h0000123 at t, out_ready=1 ->
//   - out_valid at t+2 only, out_data=28'h0000123, out_idx=5.
//  Round-robin: cores 0, 3, 37 valid same cycle, ready=1 ->
//   - out_idx 0, 3, 37 on consecutive cycles.
//   - Next burst from cores 0 and 37 -> 0 first, then 37.
//  Backpressure: out_ready=0; core 2 sends 28'h10 then, 4 cycles later, 28'h20; core 4 sends 28'h30 ->
//   - out_data=28'h10 held; 28'h20 slot-captured, no ovf.
//   - A 3rd core-2 value sets ovf=1.
//   - On ready: 28'h10, 28'h20, 28'h30 in that order.
//  Early valid: core 20 valid during REL before its release -> no output, ovf=0.
//  Restart while out_valid=1 with 3 slots full ->
//   - Next cycle: out_valid=0, core_rst all 1, ovf=0.
//   - Release sequence repeats.
//  SCHED_OVF_CNT_EN build: 5 drops -> ovf_cnt=5; restart -> 0.

Source files
------------

// File: rtl/taylor_sched_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | taylor_sched_pkg                                                   |
// | Shared sizing, FSM encoding and helpers for taylor_core_sched.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package taylor_sched_pkg;

    localparam int N_CORES   = 38;
    localparam int DW        = 28;
    localparam int STAGGER   = 9;
    localparam int IDX_W     = $clog2(N_CORES);
    localparam int CNT_W     = (STAGGER > 1) ? $clog2(STAGGER) : 1;
    localparam int OVF_CNT_W = 16;

    typedef enum logic [0:0] {
        REL = 1'b0,
        RUN = 1'b1
    } sched_state_e;

    function automatic logic [OVF_CNT_W-1:0] popcount(input logic [N_CORES-1:0] v);
        logic [OVF_CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < N_CORES; i++) begin
            n = n + OVF_CNT_W'(v[i]);
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/taylor_core_sched_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_arbiter                                                         |
// | Round-robin arbiter: first request at or after ptr+1 (wrapping).   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    logic [IW-1:0] w_cand;

    // Scan ptr+1 .. ptr+N so the last winner has the lowest priority.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        w_cand  = '0;
        for (int k = 1; k <= N; k++) begin
            w_cand = IW'((int'(ptr_i) + k) % N);
            if (!valid_o && req_i[w_cand]) begin
                valid_o       = 1'b1;
                idx_o         = w_cand;
                gnt_o[w_cand] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/taylor_core_sched.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | taylor_core_sched                                                  |
// | Staggered reset release, per-core result slots and round-robin     |
// | drain onto one valid/ready port. SCHED_OVF_CNT_EN adds ovf_cnt_o.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module taylor_core_sched
    import taylor_sched_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    restart_i,
    output logic [N_CORES-1:0]      core_rst_o,
    input  logic [N_CORES-1:0]      core_valid_i,
    input  logic [N_CORES*DW-1:0]   core_data_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [DW-1:0]           out_data_o,
    output logic [IDX_W-1:0]        out_idx_o,
    output logic                    all_up_o,
    output logic                    ovf_o
`ifdef SCHED_OVF_CNT_EN
    ,
    output logic [OVF_CNT_W-1:0]    ovf_cnt_o
`endif
);

    localparam logic [IDX_W:0]   REL_END  = (IDX_W+1)'(N_CORES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STAGGER - 1);
    localparam logic [IDX_W-1:0] RR_INIT  = IDX_W'(N_CORES - 1);

    sched_state_e         state_q;
    logic [IDX_W:0]       rel_idx_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [N_CORES-1:0]   core_rst_q;
    logic                 all_up_q;

    logic [N_CORES-1:0]   slot_full_q;
    logic [N_CORES-1:0]   slot_full_d;
    logic [DW-1:0]        slot_data_q [N_CORES];
    logic [IDX_W-1:0]     rr_ptr_q;
    logic                 out_valid_q;
    logic [DW-1:0]        out_data_q;
    logic [IDX_W-1:0]     out_idx_q;
    logic                 ovf_q;

    logic [N_CORES-1:0]   w_gnt;
    logic [IDX_W-1:0]     w_gidx;
    logic                 w_gvalid;
    logic                 w_drain_en;
    logic [N_CORES-1:0]   w_drained;
    logic [N_CORES-1:0]   w_cap;
    logic [N_CORES-1:0]   w_drop;
    logic [N_CORES-1:0]   w_write;

    // Release sequencer; rel_idx_q carries one extra bit so it can reach N_CORES.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= REL;
            rel_idx_q  <= '0;
            cnt_q      <= '0;
            core_rst_q <= '1;
            all_up_q   <= 1'b0;
        end else if (restart_i) begin
            state_q    <= REL;
            rel_idx_q  <= '0;
            cnt_q      <= '0;
            core_rst_q <= '1;
            all_up_q   <= 1'b0;
        end else begin
            case (state_q)
                REL: begin
                    if (rel_idx_q == REL_END) begin
                        state_q  <= RUN;
                        all_up_q <= 1'b1;
                    end else begin
                        if (cnt_q == '0) begin
                            core_rst_q[rel_idx_q[IDX_W-1:0]] <= 1'b0;
                        end
                        if (cnt_q == CNT_LAST) begin
                            cnt_q     <= '0;
                            rel_idx_q <= rel_idx_q + 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                RUN: begin
                    state_q <= RUN;
                end
                default: begin
                    state_q <= REL;
                end
            endcase
        end
    end

    rr_arbiter #(
        .N  (N_CORES),
        .IW (IDX_W)
    ) u_arb (
        .req_i   (slot_full_q),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (w_gnt),
        .idx_o   (w_gidx),
        .valid_o (w_gvalid)
    );

    assign w_drain_en = !out_valid_q || out_ready_i;
    assign w_drained  = w_drain_en ? w_gnt : '0;
    assign w_cap      = core_valid_i & ~core_rst_q;
    // A slot being drained on this edge can accept a new value without loss.
    assign w_drop     = w_cap & slot_full_q & ~w_drained;
    assign w_write    = w_cap & ~w_drop;
    assign slot_full_d = (slot_full_q & ~w_drained) | w_write;

    for (genvar gi = 0; gi < N_CORES; gi++) begin : g_slot
        always_ff @(posedge clk) begin
            if (w_write[gi]) begin
                slot_data_q[gi] <= core_data_i[gi*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_full_q <= '0;
            rr_ptr_q    <= RR_INIT;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            ovf_q       <= 1'b0;
        end else if (restart_i) begin
            slot_full_q <= '0;
            rr_ptr_q    <= RR_INIT;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            ovf_q       <= 1'b0;
        end else begin
            slot_full_q <= slot_full_d;
            if (|w_drop) begin
                ovf_q <= 1'b1;
            end
            if (w_drain_en) begin
                out_valid_q <= w_gvalid;
                if (w_gvalid) begin
                    out_data_q <= slot_data_q[w_gidx];
                    out_idx_q  <= w_gidx;
                    rr_ptr_q   <= w_gidx;
                end
            end
        end
    end

`ifdef SCHED_OVF_CNT_EN
    logic [OVF_CNT_W-1:0] ovf_cnt_q;
    logic [OVF_CNT_W:0]   w_ovf_sum;

    assign w_ovf_sum = {1'b0, ovf_cnt_q} + {1'b0, popcount(w_drop)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt_q <= '0;
        end else if (restart_i) begin
            ovf_cnt_q <= '0;
        end else if (w_ovf_sum[OVF_CNT_W]) begin
            ovf_cnt_q <= '1;
        end else begin
            ovf_cnt_q <= w_ovf_sum[OVF_CNT_W-1:0];
        end
    end

    assign ovf_cnt_o = ovf_cnt_q;
`endif

    assign core_rst_o  = core_rst_q;
    assign all_up_o    = all_up_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_idx_o   = out_idx_q;
    assign ovf_o       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_taylor_core_sched.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_taylor_core_sched                                               |
// | Directed self-checking bench with an expected-result scoreboard.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_taylor_core_sched;
    import taylor_sched_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  restart_i = 1'b0;
    logic                  out_ready_i = 1'b0;
    logic [N_CORES-1:0]    core_valid_i = '0;
    logic [N_CORES*DW-1:0] core_data_i = '0;
    logic [N_CORES-1:0]    core_rst_o;
    logic                  out_valid_o;
    logic [DW-1:0]         out_data_o;
    logic [IDX_W-1:0]      out_idx_o;
    logic                  all_up_o;
    logic                  ovf_o;
`ifdef SCHED_OVF_CNT_EN
    logic [15:0]           ovf_cnt_o;
`endif

    taylor_core_sched dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .restart_i    (restart_i),
        .core_rst_o   (core_rst_o),
        .core_valid_i (core_valid_i),
        .core_data_i  (core_data_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_data_o   (out_data_o),
        .out_idx_o    (out_idx_o),
        .all_up_o     (all_up_o),
        .ovf_o        (ovf_o)
`ifdef SCHED_OVF_CNT_EN
        ,
        .ovf_cnt_o    (ovf_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0]    data;
        logic [IDX_W-1:0] idx;
    } exp_t;

    exp_t             sb_q[$];
    int               n_checks = 0;
    int               n_fail   = 0;
    logic             mon_en   = 1'b0;
    logic             held_v   = 1'b0;
    logic [DW-1:0]    held_data;
    logic [IDX_W-1:0] held_idx;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [DW-1:0] d, input int idx);
        exp_t e;
        e.data = d;
        e.idx  = IDX_W'(idx);
        sb_q.push_back(e);
    endtask

    task automatic drive(input int core, input logic [DW-1:0] d);
        core_valid_i[core]          = 1'b1;
        core_data_i[core*DW +: DW]  = d;
    endtask

    // Output monitor at the falling edge, then advance to just after the next rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (mon_en) begin
            if (held_v && out_valid_o) begin
                check("hold_data", 64'(out_data_o), 64'(held_data));
                check("hold_idx", 64'(out_idx_o), 64'(held_idx));
            end
            if (out_valid_o && out_ready_i) begin
                check("sb_nonempty", 64'(sb_q.size() > 0), 64'd1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("sb_data", 64'(out_data_o), 64'(e.data));
                    check("sb_idx", 64'(out_idx_o), 64'(e.idx));
                end
            end
            held_v    = out_valid_o && !out_ready_i;
            held_data = out_data_o;
            held_idx  = out_idx_o;
        end else begin
            held_v = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic release_check(input int early_core);
        logic [N_CORES-1:0] er;
        for (int c = 1; c <= 345; c++) begin
            if (c == 4 && early_core >= 0) drive(early_core, 28'h0ABCDEF);
            if (c == 5) core_valid_i = '0;
            tick();
            for (int k = 0; k < N_CORES; k++) er[k] = (c < 1 + STAGGER * k);
            check("rel_core_rst", 64'(core_rst_o), 64'(er));
            check("rel_all_up", 64'(all_up_o), 64'(c >= STAGGER * N_CORES + 1));
            check("rel_quiet", 64'(out_valid_o), 64'd0);
            check("rel_ovf", 64'(ovf_o), 64'd0);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_core_rst", 64'(core_rst_o), 64'({N_CORES{1'b1}}));
        check("rst_out_valid", 64'(out_valid_o), 64'd0);
        check("rst_out_data", 64'(out_data_o), 64'd0);
        check("rst_out_idx", 64'(out_idx_o), 64'd0);
        check("rst_all_up", 64'(all_up_o), 64'd0);
        check("rst_ovf", 64'(ovf_o), 64'd0);
`ifdef SCHED_OVF_CNT_EN
        check("rst_ovf_cnt", 64'(ovf_cnt_o), 64'd0);
`endif
        rst_n       = 1'b1;
        out_ready_i = 1'b1;
        mon_en      = 1'b1;
        release_check(-1);

        // Round-robin from the reset pointer
        push_exp(28'h100, 0); push_exp(28'h103, 3); push_exp(28'h137, 37);
        drive(0, 28'h100); drive(3, 28'h103); drive(37, 28'h137);
        tick(); core_valid_i = '0;
        check("rr_lat", 64'(out_valid_o), 64'd0);
        tick(); check("rr_idx0", 64'(out_idx_o), 64'd0);
        tick(); check("rr_idx1", 64'(out_idx_o), 64'd3);
        tick(); check("rr_idx2", 64'(out_idx_o), 64'd37);
        tick(); check("rr_idle", 64'(out_valid_o), 64'd0);
        push_exp(28'h200, 0); push_exp(28'h237, 37);
        drive(0, 28'h200); drive(37, 28'h237);
        tick(); core_valid_i = '0;
        tick(); check("rr2_idx0", 64'(out_idx_o), 64'd0);
        tick(); check("rr2_idx1", 64'(out_idx_o), 64'd37);
        tick(); check("rr2_idle", 64'(out_valid_o), 64'd0);

        // Single result latency
        push_exp(28'h0000123, 5);
        drive(5, 28'h0000123);
        tick(); core_valid_i = '0;
        check("single_t1", 64'(out_valid_o), 64'd0);
        tick();
        check("single_t2_v", 64'(out_valid_o), 64'd1);
        check("single_t2_d", 64'(out_data_o), 64'h0000123);
        check("single_t2_i", 64'(out_idx_o), 64'd5);
        tick(); check("single_t3", 64'(out_valid_o), 64'd0);

        // Backpressure
        out_ready_i = 1'b0;
        push_exp(28'h10, 2);
        drive(2, 28'h10);
        tick(); core_valid_i = '0;
        tick();
        check("bp_v", 64'(out_valid_o), 64'd1);
        check("bp_d", 64'(out_data_o), 64'h10);
        check("bp_i", 64'(out_idx_o), 64'd2);
        tick(); tick();
        push_exp(28'h20, 2);
        drive(2, 28'h20);
        tick(); core_valid_i = '0;
        check("bp_hold", 64'(out_data_o), 64'h10);
        check("bp_no_ovf", 64'(ovf_o), 64'd0);
        tick();
        drive(2, 28'h40);
        tick(); core_valid_i = '0;
        check("bp_ovf", 64'(ovf_o), 64'd1);
        check("bp_hold2", 64'(out_data_o), 64'h10);
        out_ready_i = 1'b1;
        push_exp(28'h30, 4);
        drive(4, 28'h30);
        tick(); core_valid_i = '0;
        check("bp_d20", 64'(out_data_o), 64'h20);
        tick(); check("bp_d30", 64'(out_data_o), 64'h30);
        check("bp_i30", 64'(out_idx_o), 64'd4);
        tick(); check("bp_idle", 64'(out_valid_o), 64'd0);
        check("bp_sb_empty", 64'(sb_q.size()), 64'd0);
`ifdef SCHED_OVF_CNT_EN
        check("bp_ovf_cnt", 64'(ovf_cnt_o), 64'd1);
`endif

        // Restart with output busy and three slots full
        mon_en      = 1'b0;
        out_ready_i = 1'b0;
        drive(6, 28'h6); drive(7, 28'h7); drive(8, 28'h8); drive(9, 28'h9);
        tick(); core_valid_i = '0;
        tick();
        drive(7, 28'h17); drive(8, 28'h18); drive(9, 28'h19);
        tick(); core_valid_i = '0;
        drive(7, 28'h27);
        tick(); core_valid_i = '0;
        check("pre_rs_v", 64'(out_valid_o), 64'd1);
        check("pre_rs_i", 64'(out_idx_o), 64'd6);
        check("pre_rs_ovf", 64'(ovf_o), 64'd1);
`ifdef SCHED_OVF_CNT_EN
        check("pre_rs_ovf_cnt", 64'(ovf_cnt_o), 64'd5);
`endif
        restart_i = 1'b1;
        tick();
        restart_i = 1'b0;
        check("rs_out_valid", 64'(out_valid_o), 64'd0);
        check("rs_core_rst", 64'(core_rst_o), 64'({N_CORES{1'b1}}));
        check("rs_ovf", 64'(ovf_o), 64'd0);
        check("rs_all_up", 64'(all_up_o), 64'd0);
        check("rs_out_data", 64'(out_data_o), 64'd0);
`ifdef SCHED_OVF_CNT_EN
        check("rs_ovf_cnt", 64'(ovf_cnt_o), 64'd0);
`endif
        out_ready_i = 1'b1;
        mon_en      = 1'b1;
        release_check(20);

        push_exp(28'h999, 9);
        drive(9, 28'h999);
        tick(); core_valid_i = '0;
        tick();
        check("post_v", 64'(out_valid_o), 64'd1);
        check("post_i", 64'(out_idx_o), 64'd9);
        tick();
        check("post_idle", 64'(out_valid_o), 64'd0);
        check("final_sb_empty", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
